// File: rtl/codec_frame_mixer.sv
// Multi-channel attenuate/pan mixer feeding left-justified stereo words to the ADAU1761 codec.
// Optional MIXER_SOFT_MUTE_EN: mute halves the previous output each frame instead of zeroing it.
module codec_frame_mixer #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned OUT_W    = 24,
    parameter int unsigned GAIN_W   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         new_frame,
    input  logic [CHANNELS*SAMPLE_W-1:0] samples_in,
    input  logic [CHANNELS-1:0]          sample_valid,
    input  logic [CHANNELS*GAIN_W-1:0]   gain,
    input  logic [CHANNELS-1:0]          pan,
    input  logic                         mute,
    input  logic                         clip_clear,
    output logic [OUT_W-1:0]             hphone_l,
    output logic [OUT_W-1:0]             hphone_r,
    output logic                         sample_req,
    output logic                         busy,
    output logic                         clip,
    output logic                         overrun
);

    localparam int unsigned AW  = SAMPLE_W + $clog2(CHANNELS) + 1;
    localparam int unsigned IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PAD = OUT_W - SAMPLE_W;

    localparam logic signed [SAMPLE_W-1:0] SMAX_S = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SMIN_S = ~SMAX_S;
    localparam logic signed [AW-1:0]       SMAX   = AW'(SMAX_S);
    localparam logic signed [AW-1:0]       SMIN   = AW'(SMIN_S);

    typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} state_t;

    state_t                     state, state_nx;
    logic [IW-1:0]              idx;
    logic signed [AW-1:0]       acc_l, acc_r;
    logic signed [SAMPLE_W-1:0] out_l, out_r;

    logic signed [SAMPLE_W-1:0] cur_sample;
    logic [GAIN_W-1:0]          cur_gain;
    logic signed [AW-1:0]       addend;
    logic                       last;
    logic signed [SAMPLE_W-1:0] sat_l, sat_r, mute_l, mute_r;
    logic                       ovf_l, ovf_r;

    // One step toward silence; -1 would otherwise stick under arithmetic shift.
    function automatic logic signed [SAMPLE_W-1:0] halve(input logic signed [SAMPLE_W-1:0] x);
        return (&x) ? '0 : (x >>> 1);
    endfunction

    // Current channel select, attenuation, and saturation of both sides
    always_comb begin
        cur_sample = samples_in[32'(idx)*SAMPLE_W +: SAMPLE_W];
        cur_gain   = gain[32'(idx)*GAIN_W +: GAIN_W];
        addend     = AW'(cur_sample) >>> cur_gain;
        last       = (idx == IW'(CHANNELS - 1));

        ovf_l = (acc_l > SMAX) || (acc_l < SMIN);
        ovf_r = (acc_r > SMAX) || (acc_r < SMIN);
        sat_l = (acc_l > SMAX) ? SMAX_S : ((acc_l < SMIN) ? SMIN_S : acc_l[SAMPLE_W-1:0]);
        sat_r = (acc_r > SMAX) ? SMAX_S : ((acc_r < SMIN) ? SMIN_S : acc_r[SAMPLE_W-1:0]);
`ifdef MIXER_SOFT_MUTE_EN
        mute_l = halve(out_l);
        mute_r = halve(out_r);
`else
        mute_l = '0;
        mute_r = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (new_frame) state_nx = ACCUM;
            ACCUM:   if (last) state_nx = SAT;
            SAT:     state_nx = OUT;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: accumulate during the walk, register outputs on the SAT->OUT edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            acc_l      <= '0;
            acc_r      <= '0;
            out_l      <= '0;
            out_r      <= '0;
            sample_req <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sample_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (new_frame) begin
                        acc_l <= '0;
                        acc_r <= '0;
                        idx   <= '0;
                    end
                end
                ACCUM: begin
                    if (sample_valid[idx]) begin
                        if (pan[idx]) acc_r <= acc_r + addend;
                        else          acc_l <= acc_l + addend;
                    end
                    if (!last) idx <= idx + IW'(1);
                end
                SAT: begin
                    sample_req <= 1'b1;
                    out_l      <= mute ? mute_l : sat_l;
                    out_r      <= mute ? mute_r : sat_r;
                end
                default: ;
            endcase

            if (clip_clear)                   clip <= 1'b0;
            else if (state == SAT && (ovf_l || ovf_r)) clip <= 1'b1;

            if (clip_clear)                       overrun <= 1'b0;
            else if (new_frame && state != IDLE) overrun <= 1'b1;
        end
    end

    assign hphone_l = OUT_W'($unsigned(out_l)) << PAD;
    assign hphone_r = OUT_W'($unsigned(out_r)) << PAD;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_codec_frame_mixer.sv
// Directed bench for codec_frame_mixer with a queue scoreboard fed by a behavioural mix model.
module tb_codec_frame_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_frame;
    logic [63:0] samples_in;
    logic [3:0]  sample_valid;
    logic [11:0] gain;
    logic [3:0]  pan;
    logic        mute;
    logic        clip_clear;
    logic [23:0] hphone_l, hphone_r;
    logic        sample_req, busy, clip, overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] l;
        logic [23:0] r;
        bit          clp;
    } exp_t;

    exp_t exp_q[$];
    int   prev_l = 0, prev_r = 0;
    bit   exp_clip = 0, exp_ovr = 0;

    codec_frame_mixer dut (
        .clk(clk), .reset(reset), .new_frame(new_frame), .samples_in(samples_in),
        .sample_valid(sample_valid), .gain(gain), .pan(pan), .mute(mute),
        .clip_clear(clip_clear), .hphone_l(hphone_l), .hphone_r(hphone_r),
        .sample_req(sample_req), .busy(busy), .clip(clip), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int clamp(input int a, output bit c);
        c = 1'b0;
        if (a > 32767)  begin c = 1'b1; return 32767;  end
        if (a < -32768) begin c = 1'b1; return -32768; end
        return a;
    endfunction

    function automatic int soft_step(input int v);
        if (v >= -1 && v <= 1) return 0;
        return v >>> 1;
    endfunction

    function automatic logic [23:0] word(input int v);
        logic [15:0] t;
        t = 16'(v);
        return {t, 8'h00};
    endfunction

    // Model of one frame from the inputs currently driven
    task automatic push_exp();
        int   al, ar, s, v, rl, rr;
        bit   cl, cr;
        exp_t e;
        al = 0;
        ar = 0;
        for (int i = 0; i < 4; i++) begin
            if (sample_valid[i]) begin
                s = int'($signed(samples_in[i*16 +: 16]));
                v = s >>> gain[i*3 +: 3];
                if (pan[i]) ar += v;
                else        al += v;
            end
        end
        rl = clamp(al, cl);
        rr = clamp(ar, cr);
        if (mute) begin
`ifdef MIXER_SOFT_MUTE_EN
            rl = soft_step(prev_l);
            rr = soft_step(prev_r);
`else
            rl = 0;
            rr = 0;
`endif
        end
        prev_l = rl;
        prev_r = rr;
        e.l   = word(rl);
        e.r   = word(rr);
        e.clp = cl | cr;
        exp_q.push_back(e);
    endtask

    task automatic set_ch(input int i, input logic [15:0] s, input bit v,
                          input logic [2:0] g, input bit p);
        samples_in[i*16 +: 16] = s;
        sample_valid[i]        = v;
        gain[i*3 +: 3]         = g;
        pan[i]                 = p;
    endtask

    // Runs one frame from a negedge; second_nf>0 injects another strobe in that cycle
    task automatic frame(input int second_nf);
        int   seen, at;
        exp_t e;
        seen = 0;
        at   = -1;
        push_exp();
        new_frame = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1 || k == second_nf + 1) new_frame = 1'b0;
            if (k == second_nf) new_frame = 1'b1;
            check($sformatf("busy_k%0d", k), 32'(busy), 32'(k <= 6));
            if (sample_req) begin
                seen++;
                at = k;
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("hphone_l", 32'(hphone_l), 32'(e.l));
                    check("hphone_r", 32'(hphone_r), 32'(e.r));
                    if (e.clp) exp_clip = 1'b1;
                end
            end
        end
        new_frame = 1'b0;
        if (second_nf >= 1 && second_nf <= 6) exp_ovr = 1'b1;
        check("req_count", 32'(seen), 32'd1);
        check("req_latency", 32'(at), 32'd6);
        check("clip", 32'(clip), 32'(exp_clip));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        while (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    task automatic do_clip_clear();
        clip_clear = 1'b1;
        @(negedge clk);
        clip_clear = 1'b0;
        exp_clip = 1'b0;
        exp_ovr  = 1'b0;
        check("clip_after_clear", 32'(clip), 32'd0);
        check("overrun_after_clear", 32'(overrun), 32'd0);
    endtask

    task automatic set_test2();
        set_ch(0, 16'h1000, 1'b1, 3'd0, 1'b0);
        set_ch(1, 16'h0800, 1'b1, 3'd1, 1'b1);
        set_ch(2, 16'h7FFF, 1'b0, 3'd0, 1'b0);
        set_ch(3, 16'h8000, 1'b0, 3'd0, 1'b1);
    endtask

    initial begin
        reset        = 1'b0;
        new_frame    = 1'($urandom);
        samples_in   = {$urandom, $urandom};
        sample_valid = 4'($urandom);
        gain         = 12'($urandom);
        pan          = 4'($urandom);
        mute         = 1'($urandom);
        clip_clear   = 1'b0;

        // Reset values under random inputs
        repeat (3) @(negedge clk);
        check("rst_hphone_l", 32'(hphone_l), 32'd0);
        check("rst_hphone_r", 32'(hphone_r), 32'd0);
        check("rst_sample_req", 32'(sample_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clip", 32'(clip), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        new_frame = 1'b0;
        mute      = 1'b0;
        reset     = 1'b1;
        @(negedge clk);

        // Basic mix with pan and gain
        set_test2();
        frame(0);
        check("t2_l_const", 32'(hphone_l), 32'h0010_0000);
        check("t2_r_const", 32'(hphone_r), 32'h0004_0000);

        // Positive saturation, sticky clip, then negative saturation
        for (int i = 0; i < 4; i++) set_ch(i, 16'h7000, 1'b1, 3'd0, 1'b0);
        frame(0);
        check("sat_pos_const", 32'(hphone_l), 32'h007F_FF00);
        set_test2();
        frame(0);
        check("clip_sticky", 32'(clip), 32'd1);
        do_clip_clear();
        for (int i = 0; i < 4; i++) set_ch(i, 16'h9000, 1'b1, 3'd0, 1'b0);
        frame(0);
        check("sat_neg_const", 32'(hphone_l), 32'h0080_0000);
        do_clip_clear();

        // Overrun: extra strobes mid-walk and in the OUT cycle
        set_test2();
        frame(3);
        check("ovr_l_const", 32'(hphone_l), 32'h0010_0000);
        do_clip_clear();
        frame(6);
        do_clip_clear();

        // Reset during ACCUM aborts the frame
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        prev_l = 0;
        prev_r = 0;
        exp_clip = 1'b0;
        exp_ovr  = 1'b0;
        @(negedge clk);
        check("abort_hphone_l", 32'(hphone_l), 32'd0);
        check("abort_hphone_r", 32'(hphone_r), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_sample_req", 32'(sample_req), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_req", 32'(sample_req), 32'd0);
        end
        frame(0);

        // Random mixes
        for (int n = 0; n < 6; n++) begin
            samples_in   = {$urandom, $urandom};
            sample_valid = 4'($urandom);
            gain         = 12'($urandom);
            pan          = 4'($urandom);
            frame(0);
        end
        do_clip_clear();

        // Mute: hard zero, or geometric decay with soft mute
        set_test2();
        frame(0);
        mute = 1'b1;
        for (int n = 0; n < 17; n++) frame(0);
        check("mute_silent_l", 32'(hphone_l), 32'd0);
        check("mute_silent_r", 32'(hphone_r), 32'd0);
        mute = 1'b0;
        frame(0);
        check("unmute_l_const", 32'(hphone_l), 32'h0010_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/codec_frame_mixer.md
Name: codec_frame_mixer

Overview:
Multi-channel mixer between the sample generators (music players, tone sources) and the ADAU1761 codec interface. On each codec frame strobe it walks all channels one per cycle and applies per-channel attenuation and left/right routing. It then saturates the result, presents left-justified 24-bit stereo words to the codec, and pulses a request so the sources produce the next sample. It is the parametrised successor of the fixed mono path {sample, 8'h00} with the right channel tied to zero.

Parameters:
CHANNELS, 4, number of source channels (1..16)
SAMPLE_W, 16, signed sample width per channel and of the saturated mix
OUT_W, 24, codec word width (OUT_W >= SAMPLE_W); mix is left-justified, low bits zero
GAIN_W, 3, width of per-channel attenuation field (arithmetic right-shift amount)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
new_frame  in  1  one-cycle strobe from codec: frame consumed, next sample wanted
samples_in  in  CHANNELS*SAMPLE_W  signed samples; channel i at [i*SAMPLE_W +: SAMPLE_W]
sample_valid  in  CHANNELS  channel i contributes only when 1
gain  in  CHANNELS*GAIN_W  channel i attenuation: sample >>> gain[i]
pan  in  CHANNELS  0 = route channel to left, 1 = route to right
mute  in  1  force silent output
clip_clear  in  1  clears the clip and overrun flags
hphone_l  out  OUT_W  left codec word
hphone_r  out  OUT_W  right codec word
sample_req  out  1  one-cycle pulse when new outputs are registered
busy  out  1  high while not IDLE
clip  out  1  sticky: a saturation occurred
overrun  out  1  sticky: new_frame arrived while busy

Behaviour:
- Reset (reset=0, async): state=IDLE; hphone_l=hphone_r=0; sample_req=0; clip=0; overrun=0; accumulators and index=0.
- Accumulators: acc_l and acc_r are signed, SAMPLE_W+$clog2(CHANNELS)+1 bits wide. Samples are sign-extended before the shift. No overflow is possible inside the accumulator.
- IDLE: on new_frame, clear acc_l/acc_r, set idx=0, go to ACCUM.
- ACCUM: one channel per cycle.
  - If sample_valid[idx], add (sample[idx] >>> gain[idx]) to acc_l when pan[idx]=0, otherwise to acc_r.
  - When idx==CHANNELS-1, go to SAT; otherwise idx++.
  - Inputs are read live in the cycle of their index. Sources must hold them stable from sample_req until the ACCUM walk ends.
- SAT: clamp each accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. Set clip=1 if either side clamped. Go to OUT.
- OUT:
  - Set hphone_x = {sat_x, (OUT_W-SAMPLE_W) zeros}, or 0 if mute=1.
  - Pulse sample_req=1 for this cycle only.
  - Go to IDLE.
- Latency: new_frame at cycle T gives outputs updated and sample_req high at cycle T+CHANNELS+2. Outputs hold between updates.
- new_frame while busy: ignored, no restart, overrun set to 1. A new_frame in the same cycle as OUT is also ignored and flagged.
- clip_clear has priority over set in the same cycle (flag reads 0 next cycle). A clamp occurring that cycle is lost.
- busy = (state != IDLE); it is combinational from the state register.
- Reset asserted mid-operation aborts immediately: no sample_req, outputs go to 0.

Optional Feature:
MIXER_SOFT_MUTE_EN
- Defined: when mute=1, each OUT cycle replaces each output with (previous sat value >>> 1). Any value in {-1, 0, 1} becomes 0, so silence is reached in at most SAMPLE_W frames. Deasserting mute restores the mix on the next OUT.
- Undefined: mute forces 0 on the next OUT (hard mute).

Test Plan:
(Tests use CHANNELS=4, SAMPLE_W=16, OUT_W=24, GAIN_W=3.)
1. Reset: hold reset=0 with random inputs -> hphone_l=hphone_r=0, sample_req=0, busy=0, clip=0, overrun=0.
2. ch0=16'h1000 pan=0 gain=0; ch1=16'h0800 pan=1 gain=1; ch2/3 invalid; pulse new_frame at T -> at T+6: hphone_l=24'h100000, hphone_r=24'h040000, sample_req high exactly 1 cycle, busy high T+1..T+6.
3. Saturation: all four channels 16'h7000 pan=0 gain=0 -> hphone_l=24'h7FFF00, clip=1 persists across frames until clip_clear. Repeat with 16'h9000 -> hphone_l=24'h800000.
4. Overrun: second new_frame at T+3 -> ignored, one sample_req at T+6, overrun=1, outputs equal to the single-frame result.
5. Reset mid-ACCUM: reset=0 at T+2 -> outputs 0, busy 0 next cycle, no sample_req. The next new_frame after release mixes normally.
6. Mute: hphone_l=24'h100000 established, set mute=1 and pulse new_frame -> 0 (hard). With MIXER_SOFT_MUTE_EN: successive frames give 24'h080000, 24'h040000, ... reaching 0 within 16 frames.
